// File: rtl/modred_pkg.sv
// rtl/modred_pkg.sv - width and Barrett shift constants shared by the modular reducer
package modred_pkg;
  localparam int MODW  = 64;
  localparam int PRODW = 128;
  localparam int MUW   = 65;
  localparam int RW    = 66;
  localparam int SH1   = 63;
  localparam int SH2   = 65;
endpackage

// File: rtl/barrett_corr.sv
// rtl/barrett_corr.sv - combinational compare-and-conditional-subtract of M from a 66-bit remainder
module barrett_corr
  import modred_pkg::*;
(
  input  logic [RW-1:0]   r,
  input  logic [MODW-1:0] m,
  output logic [RW-1:0]   y
);
  logic [RW-1:0] m_ext;

  assign m_ext = {{(RW-MODW){1'b0}}, m};
  assign y     = (r >= m_ext) ? r - m_ext : r;
endmodule

// File: rtl/barrett_reduce64.sv
// rtl/barrett_reduce64.sv - 4-stage Barrett reducer R = P mod M; BARRETT_MOD_CHECK_EN adds mod_err
module barrett_reduce64
  import modred_pkg::*;
#(
  parameter int K = MODW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PRODW-1:0] P,
  input  logic             load_mod,
  input  logic [MODW-1:0]  M_in,
  input  logic [MUW-1:0]   MU_in,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MODW-1:0]  R
`ifdef BARRETT_MOD_CHECK_EN
  ,
  output logic             mod_err
`endif
);
  localparam int Q1_LSB = SH1 + K - MODW;
  localparam int Q3_LSB = SH2 + K - MODW;

  logic             en;
  logic             s1_v, s2_v, s3_v, s4_v;
  logic [PRODW-1:0] s1_p;
  logic [MUW-1:0]   s2_q3;
  logic [RW-1:0]    s2_plo, s3_r;
  logic [MODW-1:0]  m_q;
  logic [MUW-1:0]   mu_q;
  logic [MUW-1:0]   q1, q3;
  logic [RW-1:0]    m_ext, q3m_lo, r1, r2;

  assign en        = !s4_v || out_ready;
  assign in_ready  = en;
  assign out_valid = s4_v;
  assign busy      = s1_v | s2_v | s3_v | s4_v;

  // Modulus only changes on an empty pipeline, so later stages can read m_q/mu_q directly.
  always_ff @(posedge clock) begin
    if (reset) begin
      m_q  <= '0;
      mu_q <= '0;
    end else if (load_mod && !busy) begin
      m_q  <= M_in;
      mu_q <= MU_in;
    end
  end

  assign m_ext  = {{(RW-MODW){1'b0}}, m_q};
  assign q1     = s1_p[PRODW-1:Q1_LSB];
  assign q3     = MUW'(({{MUW{1'b0}}, q1} * {{MUW{1'b0}}, mu_q}) >> Q3_LSB);
  assign q3m_lo = RW'({{(RW-MUW){1'b0}}, s2_q3} * m_ext);

  barrett_corr u_corr1 (.r(s3_r), .m(m_q), .y(r1));
  barrett_corr u_corr2 (.r(r1),   .m(m_q), .y(r2));

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_v   <= 1'b0;
      s2_v   <= 1'b0;
      s3_v   <= 1'b0;
      s4_v   <= 1'b0;
      s1_p   <= '0;
      s2_q3  <= '0;
      s2_plo <= '0;
      s3_r   <= '0;
      R      <= '0;
    end else if (en) begin
      s1_v   <= in_valid;
      s1_p   <= P;
      s2_v   <= s1_v;
      s2_q3  <= q3;
      s2_plo <= s1_p[RW-1:0];
      s3_v   <= s2_v;
      s3_r   <= s2_plo - q3m_lo;
      s4_v   <= s3_v;
      R      <= MODW'(r2);
    end
  end

`ifdef BARRETT_MOD_CHECK_EN
  // Flags an illegal modulus, or a residue that escaped both corrections.
  always_ff @(posedge clock) begin
    if (reset) begin
      mod_err <= 1'b0;
    end else if (en) begin
      mod_err <= !m_q[MODW-1] || (r2 >= m_ext);
    end
  end
`endif
endmodule

// File: tb/tb_barrett_reduce64.sv
// tb/tb_barrett_reduce64.sv - randomized self-checking bench for barrett_reduce64 against a plain-modulo model
module tb_barrett_reduce64;
  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] P;
  logic         load_mod;
  logic [63:0]  M_in;
  logic [64:0]  MU_in;
  logic         busy;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  R;
`ifdef BARRETT_MOD_CHECK_EN
  logic         mod_err;
  logic         obs_err;
  logic         err_q[$];
`endif

  localparam logic [63:0] M0  = 64'hFFFF_FFFF_FFFF_FFC5;
  localparam logic [64:0] MU0 = 65'h1_0000_0000_0000_003B;

  int errors = 0;
  int checks = 0;

  logic [63:0] model_m;
  logic [63:0] sb[$];
  int          inflight;
  logic        obs_in_ready, obs_busy, exp_busy;

  always #5 clock = ~clock;

  barrett_reduce64 dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .P        (P),
    .load_mod (load_mod),
    .M_in     (M_in),
    .MU_in    (MU_in),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .R        (R)
`ifdef BARRETT_MOD_CHECK_EN
    ,
    .mod_err  (mod_err)
`endif
  );

  function automatic logic [63:0] ref_mod(input logic [127:0] p, input logic [63:0] m);
    if (m == 64'd0) return 64'd0;
    return 64'(p % {64'd0, m});
  endfunction

  function automatic logic [64:0] mu_of(input logic [63:0] m);
    logic [128:0] n;
    n = 129'd1 << 128;
    return 65'(n / {65'd0, m});
  endfunction

  function automatic logic [127:0] rand_p();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [63:0] rand_m();
    logic [63:0] m;
    m = {$urandom(), $urandom()};
    m[63] = 1'b1;
    if (m == 64'h8000_0000_0000_0000) m[0] = 1'b1;
    return m;
  endfunction

  // Drive one cycle, sample before the next rising edge, and keep the model queue up to date.
  task automatic run_cycle(input logic iv, input logic [127:0] p, input logic ordy,
                           input logic lm, input logic [63:0] mi, input logic [64:0] mui,
                           output logic acc_in, output logic acc_out, output logic ov,
                           output logic [63:0] r);
    @(negedge clock);
    in_valid  = iv;
    P         = p;
    out_ready = ordy;
    load_mod  = lm;
    M_in      = mi;
    MU_in     = mui;
    #2;
    acc_in       = in_valid && in_ready;
    acc_out      = out_valid && out_ready;
    ov           = out_valid;
    r            = R;
    obs_in_ready = in_ready;
    obs_busy     = busy;
    exp_busy     = (inflight != 0);
`ifdef BARRETT_MOD_CHECK_EN
    obs_err = mod_err;
`endif
    if (lm && inflight == 0) model_m = mi;
    if (acc_in) begin
      sb.push_back(ref_mod(p, model_m));
`ifdef BARRETT_MOD_CHECK_EN
      err_q.push_back(!model_m[63]);
`endif
      inflight++;
    end
    if (acc_out) inflight--;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset     = 1'b1;
    in_valid  = 1'b0;
    load_mod  = 1'b0;
    out_ready = 1'b1;
    P         = '0;
    M_in      = '0;
    MU_in     = '0;
    repeat (2) @(negedge clock);
    reset    = 1'b0;
    sb.delete();
`ifdef BARRETT_MOD_CHECK_EN
    err_q.delete();
`endif
    inflight = 0;
    model_m  = '0;
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (R !== 64'd0) begin errors++; $display("FAIL reset_R got=%h want=0", R); end
  endtask

  task automatic test_directed();
    logic [127:0] pv[4];
    logic [63:0]  ev[4];
    logic ai, ao, ov, got;
    logic [63:0] r, e;
    int lat;
    pv[0] = 128'd0;
    pv[1] = {128{1'b1}};
    pv[2] = {64'd0, M0} * 128'd5 + 128'd7;
    pv[3] = {64'd0, M0};
    ev[0] = 64'd0;
    ev[1] = 64'hD98;
    ev[2] = 64'd7;
    ev[3] = 64'd0;
    run_cycle(1'b0, '0, 1'b1, 1'b1, M0, MU0, ai, ao, ov, r);
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b1, pv[i], 1'b1, 1'b0, '0, '0, ai, ao, ov, r);
      checks++; if (ai !== 1'b1) begin errors++; $display("FAIL directed_accept[%0d] got=%b want=1", i, ai); end
      lat = 0;
      got = 1'b0;
      while (!got && lat < 10) begin
        run_cycle(1'b0, '0, 1'b1, 1'b0, '0, '0, ai, ao, ov, r);
        lat++;
        if (ao) begin
          got = 1'b1;
          e = sb.pop_front();
          checks++; if (r !== ev[i]) begin errors++; $display("FAIL directed_R[%0d] got=%h want=%h", i, r, ev[i]); end
          checks++; if (lat != 4) begin errors++; $display("FAIL directed_latency[%0d] got=%0d want=4", i, lat); end
        end
      end
      if (!got) begin checks++; errors++; $display("FAIL directed_timeout[%0d] got=no_output want=output", i); end
    end
  endtask

  task automatic test_back_to_back();
    logic ai, ao, ov, iv, ordy, prev_stall, ev;
    logic [63:0] r, r_prev, e, m;
    int sent, got;
    m = rand_m();
    run_cycle(1'b0, '0, 1'b1, 1'b1, m, mu_of(m), ai, ao, ov, r);
    sent = 0;
    got = 0;
    prev_stall = 1'b0;
    r_prev = '0;
    for (int c = 0; c < 400 && got < 16; c++) begin
      iv   = (sent < 16) && ($urandom_range(3) != 0);
      ordy = $urandom_range(1) == 1;
      run_cycle(iv, rand_p(), ordy, 1'b0, '0, '0, ai, ao, ov, r);
      ev = !ov || ordy;
      checks++; if (obs_in_ready !== ev) begin errors++; $display("FAIL b2b_in_ready got=%b want=%b", obs_in_ready, ev); end
      checks++; if (obs_busy !== exp_busy) begin errors++; $display("FAIL b2b_busy got=%b want=%b", obs_busy, exp_busy); end
      if (prev_stall) begin
        checks++; if (ov !== 1'b1 || r !== r_prev) begin errors++; $display("FAIL b2b_stall_hold got=%b/%h want=1/%h", ov, r, r_prev); end
      end
      if (ai) sent++;
      if (ao) begin
        e = sb.pop_front();
        got++;
        checks++; if (r !== e) begin errors++; $display("FAIL b2b_R[%0d] got=%h want=%h", got, r, e); end
      end
      prev_stall = ov && !ordy;
      r_prev = r;
    end
    checks++; if (got != 16 || sb.size() != 0) begin errors++; $display("FAIL b2b_count got=%0d want=16 (pending %0d)", got, sb.size()); end
  endtask

  task automatic test_load_busy();
    logic ai, ao, ov;
    logic [63:0] r, e, ma, mb;
    int got;
    ma = rand_m();
    mb = rand_m();
    run_cycle(1'b0, '0, 1'b1, 1'b1, ma, mu_of(ma), ai, ao, ov, r);
    run_cycle(1'b1, rand_p(), 1'b1, 1'b0, '0, '0, ai, ao, ov, r);
    run_cycle(1'b1, rand_p(), 1'b1, 1'b1, mb, mu_of(mb), ai, ao, ov, r);
    checks++; if (obs_busy !== 1'b1) begin errors++; $display("FAIL loadbusy_busy got=%b want=1", obs_busy); end
    run_cycle(1'b1, rand_p(), 1'b1, 1'b0, '0, '0, ai, ao, ov, r);
    got = 0;
    for (int c = 0; c < 20 && sb.size() != 0; c++) begin
      run_cycle(1'b0, '0, 1'b1, 1'b0, '0, '0, ai, ao, ov, r);
      if (ao) begin
        e = sb.pop_front();
        got++;
        checks++; if (r !== e) begin errors++; $display("FAIL loadbusy_old_R[%0d] got=%h want=%h", got, r, e); end
      end
    end
    checks++; if (got != 3) begin errors++; $display("FAIL loadbusy_old_count got=%0d want=3", got); end
    run_cycle(1'b0, '0, 1'b1, 1'b1, mb, mu_of(mb), ai, ao, ov, r);
    run_cycle(1'b1, rand_p(), 1'b1, 1'b0, '0, '0, ai, ao, ov, r);
    got = 0;
    for (int c = 0; c < 20 && sb.size() != 0; c++) begin
      run_cycle(1'b0, '0, 1'b1, 1'b0, '0, '0, ai, ao, ov, r);
      if (ao) begin
        e = sb.pop_front();
        got++;
        checks++; if (r !== e) begin errors++; $display("FAIL loadbusy_new_R got=%h want=%h", r, e); end
      end
    end
    checks++; if (got != 1) begin errors++; $display("FAIL loadbusy_new_count got=%0d want=1", got); end
  endtask

  task automatic test_reset_midflight();
    logic ai, ao, ov, got;
    logic [63:0] r, e;
    int lat;
    run_cycle(1'b0, '0, 1'b1, 1'b1, M0, MU0, ai, ao, ov, r);
    for (int i = 0; i < 3; i++) run_cycle(1'b1, rand_p(), 1'b1, 1'b0, '0, '0, ai, ao, ov, r);
    do_reset();
    for (int c = 0; c < 8; c++) begin
      run_cycle(1'b0, '0, 1'b1, 1'b0, '0, '0, ai, ao, ov, r);
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL midreset_out_valid[%0d] got=%b want=0", c, ov); end
    end
    run_cycle(1'b1, rand_p(), 1'b1, 1'b1, M0, MU0, ai, ao, ov, r);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 10) begin
      run_cycle(1'b0, '0, 1'b1, 1'b0, '0, '0, ai, ao, ov, r);
      lat++;
      if (ao) begin
        got = 1'b1;
        e = sb.pop_front();
        checks++; if (r !== e) begin errors++; $display("FAIL midreset_R got=%h want=%h", r, e); end
        checks++; if (lat != 4) begin errors++; $display("FAIL midreset_latency got=%0d want=4", lat); end
      end
    end
    if (!got) begin checks++; errors++; $display("FAIL midreset_timeout got=no_output want=output"); end
  endtask

`ifdef BARRETT_MOD_CHECK_EN
  task automatic test_mod_err();
    logic ai, ao, ov, ee;
    logic [63:0] r, e, mbad;
    logic [127:0] p;
    int got;
    mbad = 64'h7FFF_FFFF_FFFF_FFFF;
    for (int k = 0; k < 2; k++) begin
      p = rand_p();
      if (k == 0) run_cycle(1'b1, p, 1'b1, 1'b1, mbad, mu_of(mbad), ai, ao, ov, r);
      else        run_cycle(1'b1, p, 1'b1, 1'b1, M0, MU0, ai, ao, ov, r);
      got = 0;
      for (int c = 0; c < 12 && sb.size() != 0; c++) begin
        run_cycle(1'b0, '0, 1'b1, 1'b0, '0, '0, ai, ao, ov, r);
        if (ao) begin
          e = sb.pop_front();
          ee = err_q.pop_front();
          got++;
          checks++; if (obs_err !== ee) begin errors++; $display("FAIL mod_err[%0d] got=%b want=%b", k, obs_err, ee); end
          if (!ee) begin
            checks++; if (r !== e) begin errors++; $display("FAIL mod_err_R[%0d] got=%h want=%h", k, r, e); end
          end
        end
      end
      checks++; if (got != 1) begin errors++; $display("FAIL mod_err_count[%0d] got=%0d want=1", k, got); end
    end
  endtask
`endif

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    load_mod  = 1'b0;
    out_ready = 1'b1;
    P         = '0;
    M_in      = '0;
    MU_in     = '0;
    inflight  = 0;
    model_m   = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_load_busy();
    test_reset_midflight();
`ifdef BARRETT_MOD_CHECK_EN
    test_mod_err();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
